// File: rtl/encoder_16x4_seq.sv
// Sequential 16-to-4 encoder: accepts a multi-hot word and emits the index of
// each set bit, one per handshake, in priority order selected by LSB_FIRST.
module encoder_16x4_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        zero_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] pend;
    logic [15:0] pend_d;
    logic [15:0] pend_minus_one;
    logic        zero_err_d;

    assign in_ready       = (state == IDLE) && en && !rst;
    assign out_valid      = (state == EMIT);
    assign pend_minus_one = pend - 16'd1;
    // A single set bit is the only case where clearing the lowest bit empties pend
    assign out_last       = (pend != 16'h0) && ((pend & pend_minus_one) == 16'h0);

    // The last assignment in the scan wins, so scan direction sets priority
    always_comb begin
        out_idx = 4'd0;
        if (LSB_FIRST) begin
            for (int i = 15; i >= 0; i--) begin
                if (pend[i]) begin
                    out_idx = 4'(i);
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pend[i]) begin
                    out_idx = 4'(i);
                end
            end
        end
    end

    always_comb begin
        state_d    = state;
        pend_d     = pend;
        zero_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_vec != 16'h0) begin
                        pend_d  = in_vec;
                        state_d = EMIT;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d[out_idx] = 1'b0;
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 16'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= 16'h0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_d;
            pend     <= pend_d;
            zero_err <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_encoder_16x4_seq.sv
// Randomized bench for encoder_16x4_seq; expected index order is derived
// directly from the set bits of each loaded word.
module tb_encoder_16x4_seq;

    localparam bit LSB_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        zero_err;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit ready_pat[$];

    always #5 clk = ~clk;

    encoder_16x4_seq #(.LSB_FIRST(LSB_FIRST)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_err  (zero_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected emission order: indices of set bits, ascending or descending
    task automatic buildOrder(input logic [15:0] word);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (word[i]) begin
                if (LSB_FIRST) exp_q.push_back(i);
                else           exp_q.push_front(i);
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        int cycles;
        en       = 1'b1;
        in_valid = 1'b1;
        in_vec   = word;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("accept_ready", 32'(in_ready), 1);
        checkOutput("idle_valid", 32'(out_valid), 0);
        nextCycle();
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
        if (word == 16'h0) begin
            @(negedge clk);
            checkOutput("zero_err_pulse", 32'(zero_err), 1);
            checkOutput("zero_no_valid", 32'(out_valid), 0);
            checkOutput("zero_in_ready", 32'(in_ready), 1);
            nextCycle();
            @(negedge clk);
            checkOutput("zero_err_clear", 32'(zero_err), 0);
            checkOutput("zero_no_valid2", 32'(out_valid), 0);
            nextCycle();
            return;
        end
        buildOrder(word);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 200) begin
            out_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'($urandom_range(0, 1));
            en        = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = 16'($urandom);
            @(negedge clk);
            checkOutput("emit_valid", 32'(out_valid), 1);
            checkOutput("emit_in_ready", 32'(in_ready), 0);
            checkOutput("emit_zero_err", 32'(zero_err), 0);
            checkOutput("emit_idx", 32'(out_idx), 32'(exp_q[0]));
            checkOutput("emit_last", 32'(out_last), (exp_q.size() == 1) ? 1 : 0);
            if (out_ready) void'(exp_q.pop_front());
            nextCycle();
            cycles++;
        end
        if (exp_q.size() != 0) checkOutput("emit_timeout", 32'(exp_q.size()), 0);
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bubble_valid", 32'(out_valid), 0);
        checkOutput("bubble_in_ready", 32'(in_ready), 1);
        nextCycle();
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 16'h0;
        out_ready = 1'b0;
        repeat (2) begin
            nextCycle();
            @(negedge clk);
            checkOutput("rst_valid", 32'(out_valid), 0);
            checkOutput("rst_in_ready", 32'(in_ready), 0);
            checkOutput("rst_zero_err", 32'(zero_err), 0);
        end
        rst = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(in_ready), 1);
        nextCycle();

        applyStimulus(16'h0001);
        applyStimulus(16'h8421);
        applyStimulus(16'h0000);
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        applyStimulus(16'h0F00);

        // en low in IDLE must block loading
        en       = 1'b0;
        in_valid = 1'b1;
        in_vec   = 16'h0005;
        @(negedge clk);
        checkOutput("en_low_ready", 32'(in_ready), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("en_low_no_load", 32'(out_valid), 0);
        checkOutput("en_low_no_zero", 32'(zero_err), 0);
        in_valid = 1'b0;
        nextCycle();

        // Reset in the middle of a full word
        en       = 1'b1;
        in_valid = 1'b1;
        in_vec   = 16'hFFFF;
        nextCycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        buildOrder(16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("full_idx", 32'(out_idx), 32'(exp_q[0]));
            checkOutput("full_last", 32'(out_last), 0);
            void'(exp_q.pop_front());
            nextCycle();
        end
        rst = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_valid", 32'(out_valid), 0);
        checkOutput("midrst_in_ready", 32'(in_ready), 0);
        checkOutput("midrst_idx", 32'(out_idx), 0);
        checkOutput("midrst_last", 32'(out_last), 0);
        rst       = 1'b0;
        out_ready = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("after_rst_valid", 32'(out_valid), 0);
        checkOutput("after_rst_ready", 32'(in_ready), 1);
        nextCycle();
        applyStimulus(16'h0002);

        for (int n = 0; n < 12; n++) begin
            applyStimulus(($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom));
        end
        applyStimulus(16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
